// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the three-master RAM port arbiter.
package ram_arb_pkg;

  localparam int NUM_MASTERS = 3;

  typedef logic [1:0] master_id_t;

  localparam master_id_t M_INSTR = 2'd0;
  localparam master_id_t M_DATA  = 2'd1;
  localparam master_id_t M_UART  = 2'd2;

  // Next master in rotating order; anything past M_UART wraps back to M_INSTR.
  function automatic master_id_t next_id(input master_id_t id);
    return (id >= M_UART) ? M_INSTR : master_id_t'(id + 2'd1);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bus interfaces: one requester port per master and the single RAM macro port.
interface ram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    gnt;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

interface ram_mem_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, addr, we, be, wdata, input rdata);
  modport slave  (input req, addr, we, be, wdata, output rdata);
endinterface

// File: rtl/ram_port_arbiter_rr.sv
// Three-way rotating round-robin picker: search starts just after the last winner.
module rr_arbiter3
  import ram_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] eligible_i,
  input  master_id_t             last_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output master_id_t             winner_o,
  output logic                   valid_o
);

  // Walk the three positions after last_i and take the first eligible one.
  always_comb begin
    master_id_t cand;
    cand     = last_i;
    grant_o  = '0;
    winner_o = M_INSTR;
    valid_o  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = next_id(cand);
      if (!valid_o && eligible_i[cand]) begin
        grant_o[cand] = 1'b1;
        winner_o      = cand;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between instruction fetch, data and UART loader.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 reset,
  input  logic                 boot_hold_i,
  ram_port_arbiter_if.slave    m0,
  ram_port_arbiter_if.slave    m1,
  ram_port_arbiter_if.slave    m2,
  ram_mem_if.master            mem,
  output logic [15:0]          conflict_cnt_o
);

  logic [NUM_MASTERS-1:0] elig_v;
  logic [NUM_MASTERS-1:0] grant_v;
  logic [NUM_MASTERS-1:0] rvalid_v;
  master_id_t             winner;
  logic                   any_gnt;
  logic                   multi_req;

  master_id_t             last_q, last_d;
  logic                   rsp_valid_q;
  master_id_t             rsp_id_q;
  logic [15:0]            conflict_q, conflict_d;

  // Core masters are locked out during boot hold; nothing is eligible in reset
  // so grants and the RAM strobe read 0 while reset is held.
  assign elig_v[M_INSTR] = m0.req & ~boot_hold_i & ~reset;
  assign elig_v[M_DATA]  = m1.req & ~boot_hold_i & ~reset;
  assign elig_v[M_UART]  = m2.req & ~reset;

  rr_arbiter3 u_rr (
    .eligible_i (elig_v),
    .last_i     (last_q),
    .grant_o    (grant_v),
    .winner_o   (winner),
    .valid_o    (any_gnt)
  );

  assign m0.gnt = grant_v[M_INSTR];
  assign m1.gnt = grant_v[M_DATA];
  assign m2.gnt = grant_v[M_UART];

  // Route the winner's request onto the RAM port; idle bus is all zeros.
  always_comb begin
    mem.req   = any_gnt;
    mem.addr  = '0;
    mem.we    = 1'b0;
    mem.be    = '0;
    mem.wdata = '0;
    if (any_gnt) begin
      case (winner)
        M_INSTR: begin
          mem.addr  = m0.addr;
          mem.we    = m0.we;
          mem.be    = m0.be;
          mem.wdata = m0.wdata;
        end
        M_DATA: begin
          mem.addr  = m1.addr;
          mem.we    = m1.we;
          mem.be    = m1.be;
          mem.wdata = m1.wdata;
        end
        M_UART: begin
          mem.addr  = m2.addr;
          mem.we    = m2.we;
          mem.be    = m2.be;
          mem.wdata = m2.wdata;
        end
        default: begin
          mem.addr  = '0;
        end
      endcase
    end
  end

  // Two or more eligible requesters in one cycle count as a conflict.
  assign multi_req = (elig_v[0] & elig_v[1]) | (elig_v[0] & elig_v[2]) | (elig_v[1] & elig_v[2]);

  // Next-state for round-robin pointer and saturating conflict counter.
  always_comb begin
    last_d     = any_gnt ? winner : last_q;
    conflict_d = conflict_q;
    if (multi_req && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  // Pointer, response tracker and counter; reset drops any in-flight response.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      last_q      <= M_UART;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= M_INSTR;
      conflict_q  <= 16'd0;
    end else begin
      last_q      <= last_d;
      rsp_valid_q <= any_gnt;
      rsp_id_q    <= winner;
      conflict_q  <= conflict_d;
    end
  end

  assign rvalid_v[M_INSTR] = rsp_valid_q && (rsp_id_q == M_INSTR);
  assign rvalid_v[M_DATA]  = rsp_valid_q && (rsp_id_q == M_DATA);
  assign rvalid_v[M_UART]  = rsp_valid_q && (rsp_id_q == M_UART);

  assign m0.rvalid = rvalid_v[M_INSTR];
  assign m1.rvalid = rvalid_v[M_DATA];
  assign m2.rvalid = rvalid_v[M_UART];

  assign m0.rdata = rvalid_v[M_INSTR] ? mem.rdata : '0;
  assign m1.rdata = rvalid_v[M_DATA]  ? mem.rdata : '0;
  assign m2.rdata = rvalid_v[M_UART]  ? mem.rdata : '0;

  assign conflict_cnt_o = conflict_q;

endmodule
